// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline-control types and the RUN-state hazard decode
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic en_w;
    logic clr_d;
    logic clr_e;
  } pipe_ctl_t;

  localparam int REG_ZERO = 0;

  localparam pipe_ctl_t CTL_FLOW  = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1, en_w: 1'b1,
                                      clr_d: 1'b0, clr_e: 1'b0};
  localparam pipe_ctl_t CTL_FREEZE = '0;

  // Branch flush outranks the load-use bubble: the loaded value is discarded anyway.
  function automatic pipe_ctl_t run_decode(input logic lu, input logic br);
    pipe_ctl_t c;
    c = CTL_FLOW;
    if (br) begin
      c.clr_d = 1'b1;
      c.clr_e = 1'b1;
    end else if (lu) begin
      c.en_f  = 1'b0;
      c.en_d  = 1'b0;
      c.clr_e = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and taken-branch hazard terms
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  memread_e,
  input  logic                  branch_taken_e,
  output logic                  lu,
  output logic                  br
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign lu = memread_e && (rd_e != REG_ADDR_W'(REG_ZERO)) &&
              ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign br = branch_taken_e;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer: stalls, flushes, memory waits, timeout halt
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  memread_e,
  input  logic                  branch_taken_e,
  input  logic                  mem_access_m,
  input  logic                  mem_ready,
  output logic                  en_f,
  output logic                  en_d,
  output logic                  en_e,
  output logic                  en_m,
  output logic                  en_w,
  output logic                  clr_d,
  output logic                  clr_e,
  output logic                  mem_start,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  pipe_ctl_t         ctl;
  logic              lu, br;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rd_e           (rd_e),
    .memread_e      (memread_e),
    .branch_taken_e (branch_taken_e),
    .lu             (lu),
    .br             (br)
  );

  always_comb begin
    ctl       = CTL_FLOW;
    mem_start = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_access_m) begin
          ctl       = CTL_FREEZE;
          mem_start = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = '0;
        end else begin
          ctl = run_decode(lu, br);
        end
      end
      MEM_WAIT: begin
        // Ready wins over a timeout landing on the same cycle.
        if (mem_ready) begin
          ctl     = run_decode(lu, br);
          state_d = RUN;
        end else begin
          ctl    = CTL_FREEZE;
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) state_d = HALT;
        end
      end
      HALT:    ctl = CTL_FREEZE;
      default: state_d = RUN;
    endcase

    if (!reset) begin
      ctl       = CTL_FLOW;
      mem_start = 1'b0;
      state_d   = RUN;
      wait_d    = '0;
    end

    stall_d = stall_q;
    if (!reset)                        stall_d = '0;
    else if (!ctl.en_f && !(&stall_q)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    wait_q  <= wait_d;
    stall_q <= stall_d;
  end

  assign en_f         = ctl.en_f;
  assign en_d         = ctl.en_d;
  assign en_e         = ctl.en_e;
  assign en_m         = ctl.en_m;
  assign en_w         = ctl.en_w;
  assign clr_d        = ctl.clr_d;
  assign clr_e        = ctl.clr_e;
  assign halted       = reset && (state_q == HALT);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

  localparam int RW  = 4;
  localparam int TO  = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] rs1_d, rs2_d, rd_e;
  logic          memread_e, branch_taken_e, mem_access_m, mem_ready;
  logic          en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, mem_start, halted;
  logic [CW-1:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model: 0 = running, 1 = waiting on memory, 2 = halted
  int m_mode   = 0;
  int m_waited = 0;
  int m_stall  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rd_e           (rd_e),
    .memread_e      (memread_e),
    .branch_taken_e (branch_taken_e),
    .mem_access_m   (mem_access_m),
    .mem_ready      (mem_ready),
    .en_f           (en_f),
    .en_d           (en_d),
    .en_e           (en_e),
    .en_m           (en_m),
    .en_w           (en_w),
    .clr_d          (clr_d),
    .clr_e          (clr_e),
    .mem_start      (mem_start),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  // One cycle: drive at negedge, check outputs shortly after, then advance the model at posedge.
  task automatic step(input logic rst, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                      input logic [RW-1:0] rd, input logic mr, input logic brt,
                      input logic macc, input logic rdy, input string tag);
    logic       hz_lu, frozen, flow;
    logic [7:0] exp_v, obs_v;
    logic       exp_h;
    @(negedge clk);
    reset = rst; rs1_d = s1; rs2_d = s2; rd_e = rd; memread_e = mr;
    branch_taken_e = brt; mem_access_m = macc; mem_ready = rdy;
    #1;
    hz_lu  = mr && (rd != 0) && (rd == s1 || rd == s2);
    frozen = rst && (m_mode == 2 || (m_mode == 1 && !rdy) || (m_mode == 0 && macc));
    flow   = !rst || !frozen;
    // vector order: en_f en_d en_e en_m en_w clr_d clr_e mem_start
    if (!flow)              exp_v = {7'b0000000, rst && m_mode == 0 && macc};
    else if (!rst)          exp_v = 8'b11111_00_0;
    else if (brt)           exp_v = 8'b11111_11_0;
    else if (hz_lu)         exp_v = 8'b00111_01_0;
    else                    exp_v = 8'b11111_00_0;
    exp_h = rst && m_mode == 2;
    obs_v = {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, mem_start};

    n_assert++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s ctl: got %b expected %b", tag, obs_v, exp_v);
    end
    n_assert++;
    assert (halted === exp_h) else begin
      n_fail++;
      $error("FAIL %s halted: got %b expected %b", tag, halted, exp_h);
    end
    n_assert++;
    assert (stall_cycles === CW'(m_stall)) else begin
      n_fail++;
      $error("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, m_stall);
    end

    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_waited = 0; m_stall = 0;
    end else begin
      if (!exp_v[7] && m_stall < (1 << CW) - 1) m_stall++;
      if (m_mode == 0 && macc) begin
        m_mode = 1; m_waited = 0;
      end else if (m_mode == 1) begin
        if (rdy) m_mode = 0;
        else begin
          m_waited++;
          if (m_waited == TO) m_mode = 2;
        end
      end
    end
  endtask

  task automatic idle(input logic rst, input string tag);
    step(rst, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic wait_n(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic mem_go(input string tag);
    step(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b0; rs1_d = '0; rs2_d = '0; rd_e = '0; memread_e = 1'b0;
    branch_taken_e = 1'b0; mem_access_m = 1'b0; mem_ready = 1'b0;

    idle(1'b0, "reset0");
    idle(1'b0, "reset1");
    idle(1'b1, "post_reset");

    step(1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, "lu_stall");
    idle(1'b1, "lu_after");
    step(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "lu_r0");
    step(1'b1, 4'd2, 4'd7, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, "lu_rs2");

    step(1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, "br_vs_lu");
    idle(1'b1, "br_after");

    mem_go("mem_start");
    wait_n(3, "mem_wait");
    step(1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, "mem_release_lu");
    idle(1'b1, "mem_after");

    mem_go("to_start");
    wait_n(TO, "to_wait");
    step(1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, "halt_ignores");
    idle(1'b0, "halt_reset");
    idle(1'b1, "halt_cleared");

    mem_go("tie_start");
    wait_n(TO - 1, "tie_wait");
    step(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, "tie_ready");
    idle(1'b1, "tie_run");

    mem_go("sat_start");
    wait_n(TO, "sat_wait");
    wait_n(20, "sat_halt");
    idle(1'b0, "sat_reset");

    mem_go("mw_start");
    wait_n(2, "mw_wait");
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "mw_reset");
    idle(1'b1, "mw_run");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0,
           RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 2, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
